// File: rtl/wb_stage.sv
// Write-back stage: holds one retiring instruction, waits for load data, extends/merges it
// and issues one register write per instruction. Optional WB_DMEM_TIMEOUT_EN adds a WAIT timeout.
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mem_to_reg,
    input  logic             in_reg_write,
    input  logic [4:0]       in_reg_id,
    input  logic [5:0]       in_opcode,
    input  logic [1:0]       in_addr_lo,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_rt_old,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             reg_write_o,
    output logic [4:0]       reg_write_id_o,
    output logic [31:0]      reg_write_data_o,
    output logic             stall_o,
    output logic             addr_err_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, COMMIT = 2'd2} state_t;

    function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] k,
                                                 input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{k, 3'b000} +: 8];
        h = k[1] ? rd[31:16] : rd[15:0];
        case (op)
            6'h20:   r = {{24{b[7]}}, b};
            6'h24:   r = {24'd0, b};
            6'h21:   r = {{16{h[15]}}, h};
            6'h25:   r = {16'd0, h};
            6'h22: begin
                case (k)
                    2'd0:    r = {rd[7:0], rt[23:0]};
                    2'd1:    r = {rd[15:0], rt[15:0]};
                    2'd2:    r = {rd[23:0], rt[7:0]};
                    default: r = rd;
                endcase
            end
            6'h26: begin
                case (k)
                    2'd0:    r = rd;
                    2'd1:    r = {rt[31:24], rd[31:8]};
                    2'd2:    r = {rt[31:16], rd[31:16]};
                    default: r = {rt[31:8], rd[31:24]};
                endcase
            end
            default: r = rd;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] k);
        logic m;
        case (op)
            6'h21, 6'h25: m = k[0];
            6'h23:        m = (k != 2'd0);
            default:      m = 1'b0;
        endcase
        return m;
    endfunction

    state_t            state_r, state_s;
    logic              in_ready_r, stall_r;
    logic              we_r, aerr_r, berr_r;
    logic [4:0]        id_r;
    logic [31:0]       data_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              h_reg_write_r, h_misalign_r;
    logic [4:0]        h_reg_id_r;
    logic [5:0]        h_opcode_r;
    logic [1:0]        h_addr_lo_r;
    logic [31:0]       h_rt_old_r;
    logic              accept_s, tmo_hit_s;
    logic              nxt_we_s, nxt_aerr_s, nxt_berr_s;
    logic [4:0]        nxt_id_s;
    logic [31:0]       nxt_data_s;

    assign accept_s = in_valid && in_ready_r;

`ifdef WB_DMEM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TMO_W-1:0] tmo_r;

    // WAIT-cycle counter, restarted whenever a new instruction is accepted
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (accept_s) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (state_r == WAIT && !dmem_rvalid) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end else begin
            tmo_r <= tmo_r;
        end
    end

    assign tmo_hit_s = (state_r == WAIT) && (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_s = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and the values to be committed on entry to COMMIT
    always_comb begin
        state_s    = state_r;
        nxt_we_s   = 1'b0;
        nxt_aerr_s = 1'b0;
        nxt_berr_s = 1'b0;
        nxt_id_s   = in_reg_id;
        nxt_data_s = in_alu_result;
        case (state_r)
            IDLE, COMMIT: begin
                if (accept_s) begin
                    state_s = in_mem_to_reg ? WAIT : COMMIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (dmem_rvalid || tmo_hit_s) begin
                    state_s = COMMIT;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
        if (state_r == WAIT) begin
            nxt_id_s   = h_reg_id_r;
            nxt_data_s = load_extract(h_opcode_r, h_addr_lo_r, dmem_rdata, h_rt_old_r);
            nxt_aerr_s = h_misalign_r;
            nxt_berr_s = !dmem_rvalid && tmo_hit_s;
            nxt_we_s   = h_reg_write_r && (h_reg_id_r != 5'd0) && !nxt_aerr_s && !nxt_berr_s;
        end else begin
            nxt_we_s   = in_reg_write && (in_reg_id != 5'd0);
        end
    end

    // Held instruction and registered outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r    <= 1'b0;
            stall_r       <= 1'b0;
            we_r          <= 1'b0;
            aerr_r        <= 1'b0;
            berr_r        <= 1'b0;
            id_r          <= 5'd0;
            data_r        <= 32'd0;
            cnt_r         <= {CNT_W{1'b0}};
            h_reg_write_r <= 1'b0;
            h_misalign_r  <= 1'b0;
            h_reg_id_r    <= 5'd0;
            h_opcode_r    <= 6'd0;
            h_addr_lo_r   <= 2'd0;
            h_rt_old_r    <= 32'd0;
        end else begin
            in_ready_r <= (state_s != WAIT);
            stall_r    <= (state_s == WAIT);
            if (accept_s) begin
                h_reg_write_r <= in_reg_write;
                h_misalign_r  <= in_mem_to_reg && is_misaligned(in_opcode, in_addr_lo);
                h_reg_id_r    <= in_reg_id;
                h_opcode_r    <= in_opcode;
                h_addr_lo_r   <= in_addr_lo;
                h_rt_old_r    <= in_rt_old;
            end else begin
                h_reg_write_r <= h_reg_write_r;
                h_misalign_r  <= h_misalign_r;
                h_reg_id_r    <= h_reg_id_r;
                h_opcode_r    <= h_opcode_r;
                h_addr_lo_r   <= h_addr_lo_r;
                h_rt_old_r    <= h_rt_old_r;
            end
            if (state_s == COMMIT) begin
                we_r   <= nxt_we_s;
                aerr_r <= nxt_aerr_s;
                berr_r <= nxt_berr_s;
                id_r   <= nxt_id_s;
                data_r <= nxt_data_s;
                cnt_r  <= cnt_r + CNT_W'(1);
            end else begin
                we_r   <= 1'b0;
                aerr_r <= 1'b0;
                berr_r <= 1'b0;
                id_r   <= id_r;
                data_r <= data_r;
                cnt_r  <= cnt_r;
            end
        end
    end

    assign in_ready         = in_ready_r;
    assign stall_o          = stall_r;
    assign reg_write_o      = we_r;
    assign reg_write_id_o   = id_r;
    assign reg_write_data_o = data_r;
    assign addr_err_o       = aerr_r;
    assign bus_err_o        = berr_r;
    assign retired_cnt      = cnt_r;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected commits, a monitor pops them
// whenever retired_cnt advances.
module tb_wb_stage;
    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_mem_to_reg = 1'b0, in_reg_write = 1'b0;
    logic [4:0]  in_reg_id = 5'd0;
    logic [5:0]  in_opcode = 6'd0;
    logic [1:0]  in_addr_lo = 2'd0;
    logic [31:0] in_alu_result = 32'd0, in_rt_old = 32'd0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        reg_write_o, stall_o, addr_err_o, bus_err_o;
    logic [4:0]  reg_write_id_o;
    logic [31:0] reg_write_data_o, retired_cnt;

    wb_stage #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_reg_id(in_reg_id),
        .in_opcode(in_opcode), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
        .in_rt_old(in_rt_old), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .reg_write_o(reg_write_o), .reg_write_id_o(reg_write_id_o),
        .reg_write_data_o(reg_write_data_o), .stall_o(stall_o), .addr_err_o(addr_err_o),
        .bus_err_o(bus_err_o), .retired_cnt(retired_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        we;
        logic [4:0]  id;
        logic [31:0] data;
        logic        aerr;
        logic        berr;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [1:0]  k;
        logic [31:0] rdata;
        logic [31:0] rt;
        int          delay;
        logic [31:0] exp_data;
        logic        exp_aerr;
    } ld_vec_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    endtask

    task automatic push(input logic we, input logic [4:0] id, input logic [31:0] data,
                        input logic aerr, input logic berr);
        exp_t e;
        exp_cnt   = exp_cnt + 32'd1;
        e.we      = we;
        e.id      = id;
        e.data    = data;
        e.aerr    = aerr;
        e.berr    = berr;
        e.cnt     = exp_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per retired_cnt step, no events in between
    initial begin
        logic [31:0] prev;
        exp_t e;
        prev = 32'd0;
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                prev = 32'd0;
            end else if (retired_cnt != prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", retired_cnt, prev);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_cnt", retired_cnt, e.cnt);
                    check("commit_we", {31'd0, reg_write_o}, {31'd0, e.we});
                    check("commit_addr_err", {31'd0, addr_err_o}, {31'd0, e.aerr});
                    check("commit_bus_err", {31'd0, bus_err_o}, {31'd0, e.berr});
                    if (e.we) begin
                        check("commit_id", {27'd0, reg_write_id_o}, {27'd0, e.id});
                        check("commit_data", reg_write_data_o, e.data);
                    end
                end
                prev = retired_cnt;
            end else if (reg_write_o || addr_err_o || bus_err_o) begin
                check("spurious_event", {29'd0, reg_write_o, addr_err_o, bus_err_o}, 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_alu(input logic [4:0] id, input logic [31:0] data, input logic rw);
        wait_ready();
        in_valid = 1'b1; in_mem_to_reg = 1'b0; in_reg_write = rw;
        in_reg_id = id; in_alu_result = data; in_opcode = 6'h00;
        push(rw && (id != 5'd0), id, data, 1'b0, 1'b0);
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        check("alu_no_stall", {31'd0, stall_o}, 32'd0);
    endtask

    task automatic send_load(input ld_vec_t v, input logic [4:0] id);
        wait_ready();
        in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1; in_reg_id = id;
        in_opcode = v.op; in_addr_lo = v.k; in_rt_old = v.rt; in_alu_result = 32'h0BAD_0BAD;
        dmem_rvalid = 1'b1; dmem_rdata = ~v.rdata;
        push(!v.exp_aerr, id, v.exp_data, v.exp_aerr, 1'b0);
        @(posedge sys_clk); #1;
        in_valid = 1'b0; dmem_rvalid = 1'b0;
        check("load_ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < v.delay - 1; i++) begin
            check("load_stall", {31'd0, stall_o}, 32'd1);
            @(posedge sys_clk); #1;
        end
        dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
        check("load_stall_last", {31'd0, stall_o}, 32'd1);
        @(posedge sys_clk); #1;
        dmem_rvalid = 1'b0;
        check("load_stall_released", {31'd0, stall_o}, 32'd0);
    endtask

    ld_vec_t lv[14];

    initial begin
        lv[0]  = '{6'h20, 2'd2, 32'h0080FF11, 32'h0,        3, 32'hFFFFFF80, 1'b0};
        lv[1]  = '{6'h24, 2'd2, 32'h0080FF11, 32'h0,        3, 32'h00000080, 1'b0};
        lv[2]  = '{6'h22, 2'd1, 32'hAABBCCDD, 32'h11223344, 1, 32'hCCDD3344, 1'b0};
        lv[3]  = '{6'h26, 2'd1, 32'hAABBCCDD, 32'h11223344, 1, 32'h11AABBCC, 1'b0};
        lv[4]  = '{6'h22, 2'd3, 32'hAABBCCDD, 32'h11223344, 2, 32'hAABBCCDD, 1'b0};
        lv[5]  = '{6'h26, 2'd0, 32'hAABBCCDD, 32'h11223344, 2, 32'hAABBCCDD, 1'b0};
        lv[6]  = '{6'h22, 2'd0, 32'hAABBCCDD, 32'h11223344, 1, 32'hDD223344, 1'b0};
        lv[7]  = '{6'h26, 2'd3, 32'hAABBCCDD, 32'h11223344, 1, 32'h112233AA, 1'b0};
        lv[8]  = '{6'h21, 2'd2, 32'h80017FFF, 32'h0,        1, 32'hFFFF8001, 1'b0};
        lv[9]  = '{6'h25, 2'd0, 32'h8001F00D, 32'h0,        2, 32'h0000F00D, 1'b0};
        lv[10] = '{6'h23, 2'd2, 32'h12345678, 32'h0,        1, 32'h0,        1'b1};
        lv[11] = '{6'h25, 2'd1, 32'h12345678, 32'h0,        1, 32'h0,        1'b1};
        lv[12] = '{6'h23, 2'd0, 32'hDEADBEEF, 32'h0,        2, 32'hDEADBEEF, 1'b0};
        lv[13] = '{6'h20, 2'd1, 32'h00007F00, 32'h0,        1, 32'h0000007F, 1'b0};

        #12;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_write", {31'd0, reg_write_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_cnt", retired_cnt, 32'd0);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        send_alu(5'd5, 32'h00001234, 1'b1);
        send_alu(5'd0, 32'hFFFFFFFF, 1'b1);
        send_alu(5'd7, 32'h55555555, 1'b0);

        for (int i = 0; i < 14; i++) send_load(lv[i], 5'(i + 1));

        // Reset while a load is pending
        wait_ready();
        in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1; in_reg_id = 5'd3;
        in_opcode = 6'h23; in_addr_lo = 2'd0;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        @(posedge sys_clk); #1;
        check("pre_rst_stall", {31'd0, stall_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_cnt", retired_cnt, 32'd0);
        check("midrst_write", {31'd0, reg_write_o}, 32'd0);
        exp_cnt = 32'd0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        #1;
        check("ready_low_after_deassert", {31'd0, in_ready}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(posedge sys_clk); #1;
        dmem_rvalid = 1'b0;
        check("late_rvalid_no_write", {31'd0, reg_write_o}, 32'd0);
        check("late_rvalid_cnt", retired_cnt, 32'd0);
        check("ready_after_midrst", {31'd0, in_ready}, 32'd1);

        // Back-to-back non-loads
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_mem_to_reg = 1'b0; in_reg_write = 1'b1;
            in_reg_id = 5'(10 + i); in_alu_result = 32'hA000_0000 + 32'(i);
            push(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            @(posedge sys_clk); #1;
            check("b2b_write", {31'd0, reg_write_o}, 32'd1);
        end
        in_valid = 1'b0;
        @(posedge sys_clk); #1;
        check("b2b_idle", {31'd0, reg_write_o}, 32'd0);

`ifdef WB_DMEM_TIMEOUT_EN
        begin
            int n;
            wait_ready();
            in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1; in_reg_id = 5'd9;
            in_opcode = 6'h23; in_addr_lo = 2'd0;
            push(1'b0, 5'd9, 32'd0, 1'b0, 1'b1);
            @(posedge sys_clk); #1;
            in_valid = 1'b0;
            n = 0;
            while (!bus_err_o && n < 100) begin
                @(posedge sys_clk); #1;
                n++;
            end
            check("timeout_cycles", 32'(n), 32'd8);
            check("timeout_ready", {31'd0, in_ready}, 32'd1);
            check("timeout_no_write", {31'd0, reg_write_o}, 32'd0);
        end
`endif

        repeat (3) @(posedge sys_clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage pipeline. It is the writer side of the register-file write port (reg_write / reg_write_id / reg_write_data) and of the decoder's is_stalling input.
- Latches one retiring instruction from MEM and waits for the data-memory read response when the instruction is a load.
- Extracts and extends load data, including lwl/lwr merging, then drives exactly one register write per retired instruction.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before a bus error (only with WB_DMEM_TIMEOUT_EN).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- sys_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  wb_stage can accept this cycle
- in_mem_to_reg  in  1  instruction is a load
- in_reg_write  in  1  instruction writes a register
- in_reg_id  in  5  destination register
- in_opcode  in  6  load opcode (lb 0x20, lh 0x21, lwl 0x22, lw 0x23, lbu 0x24, lhu 0x25, lwr 0x26)
- in_addr_lo  in  2  effective address bits [1:0]
- in_alu_result  in  32  ALU or link result
- in_rt_old  in  32  current rt value, used for lwl/lwr merging
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  aligned read word, little-endian
- reg_write_o  out  1  register write strobe
- reg_write_id_o  out  5  register write id
- reg_write_data_o  out  32  register write data
- stall_o  out  1  drives the decoder's is_stalling input
- addr_err_o  out  1  one-cycle pulse on a misaligned lh/lhu/lw
- bus_err_o  out  1  one-cycle pulse on a timeout
- retired_cnt  out  CNT_W  count of committed instructions

Behaviour:
- Reset: the clock and reset are as already decided — one clock, reset asynchronous and active-low. While rst_n = 0:
  - state = IDLE
  - all outputs 0, retired_cnt = 0, held instruction cleared
  - in_ready = 1 one cycle after reset deasserts
- States:
  - IDLE: nothing held.
  - WAIT: a load is held and awaiting data.
  - COMMIT: result is registered and is written this cycle.
- in_ready = (state != WAIT). stall_o = (state == WAIT).
- Accept: in_valid && in_ready at a rising edge.
  - Non-load: go to COMMIT with data = in_alu_result. Latency is 1 cycle.
  - Load: go to WAIT.
- WAIT:
  - On dmem_rvalid, compute load data and go to COMMIT.
  - An rvalid in the same cycle as the load's acceptance is ignored; memory responds at least 1 cycle later.
- COMMIT, for exactly one cycle:
  - reg_write_o = held reg_write && id != 0 && no error.
  - retired_cnt increments by 1 (wraps modulo 2^CNT_W).
  - A simultaneous new accept goes straight to COMMIT or WAIT; otherwise go to IDLE. Back-to-back non-loads therefore commit every cycle.
- dmem_rvalid in IDLE or COMMIT is ignored. Reset while in WAIT discards the pending load; a late rvalid afterwards is ignored.
- Load extraction (b[k] = byte k of dmem_rdata, k = in_addr_lo):
  - lb / lbu: byte k, sign- or zero-extended.
  - lh / lhu: halfword at k[1], sign- or zero-extended.
  - lw: whole word.
  - lwl, k = 0..3: {rdata[8k+7:0], rt_old[23-8k:0]}; k = 3 gives the whole word.
  - lwr, k = 0..3: {rt_old[31:32-8k], rdata[31:8k]}; k = 0 gives the whole word.
- Misalignment: lh/lhu with k[0] = 1, or lw with k != 0.
  - Detected at accept. The load still waits for rvalid.
  - In COMMIT the write is suppressed and addr_err_o pulses for 1 cycle.
  - The instruction still counts as retired.
- reg_write_o is never high while stall_o is high, because the decoder drops writes during a stall.

Optional Feature:
- Macro: WB_DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle without rvalid.
  - When it reaches TIMEOUT_CYCLES, go to COMMIT with the write suppressed and bus_err_o pulsed for 1 cycle.
  - An rvalid in the same cycle as the timeout wins, so no error is raised.
- Undefined: WAIT lasts indefinitely and bus_err_o is tied to 0.

Test Plan:
- Non-load addu: in_reg_id = 5, alu_result = 0x1234 -> next cycle reg_write_o = 1, id = 5, data = 0x00001234, retired_cnt = 1, stall_o never high.
- Signed byte: lb with k = 2, rdata = 0x0080FF11, rvalid 3 cycles after accept -> stall_o high for 3 cycles, then data = 0xFFFFFF80. The same stimulus with lbu -> 0x00000080.
- Merge: lwl k = 1, rdata = 0xAABBCCDD, rt_old = 0x11223344 -> data = 0xCCDD3344. lwr k = 1 with the same inputs -> 0x11AABBCC.
- Misaligned lw (k = 2) and write to $0: lw -> addr_err_o pulse, no write, retired_cnt increments. Non-load with id = 0 -> reg_write_o = 0.
- Reset and spurious response: rst_n pulled low while in WAIT -> outputs 0 immediately. A spurious dmem_rvalid after reset -> no write. Back-to-back non-loads over 4 cycles -> 4 consecutive writes.
- Timeout, with WB_DMEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8: no rvalid -> bus_err_o pulse 8 cycles after entering WAIT, no write, in_ready returns high.
